// File: rtl/led_pulse_stretcher_if.sv
// Event/LED bundle for led_pulse_stretcher; master is the event source and LED observer,
// slave is the stretcher itself.
interface led_pulse_stretcher_if;
  logic i_Event;
  logic o_LED_1;
  logic o_Busy;
  logic o_Overflow;

  modport master (output i_Event, input o_LED_1, o_Busy, o_Overflow);
  modport slave  (input i_Event, output o_LED_1, o_Busy, o_Overflow);
endinterface

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into LED flashes with a minimum on-time and dark gap.
// Optional macro LED_STRETCH_QUEUE_EN adds a saturating pending counter that replays queued events.
module led_pulse_stretcher #(
  parameter int ON_CYCLES  = 250000,
  parameter int OFF_CYCLES = 250000,
  parameter int PEND_W     = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  led_pulse_stretcher_if.slave  bus
);
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  generate
    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || PEND_W < 1) begin : g_bad_param
      $error("led_pulse_stretcher: ON_CYCLES, OFF_CYCLES and PEND_W must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          led, busy, ovf;
  logic          ev, ev_extra, pend_nz;

  assign ev = bus.i_Event;
  // Events that do not directly start a flash: anywhere in ON, or OFF before its last cycle.
  assign ev_extra = ev && ((state == ON) || (state == OFF && timer != OFF_LAST));

`ifdef LED_STRETCH_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic [PEND_W-1:0] pend;
  assign pend_nz = (pend != '0);
`else
  assign pend_nz = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
      timer <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
`ifdef LED_STRETCH_QUEUE_EN
      pend  <= '0;
`endif
    end else begin
      ovf <= 1'b0;
      case (state)
        IDLE: if (ev) begin
          state <= ON;
          timer <= '0;
          led   <= 1'b1;
          busy  <= 1'b1;
        end
        ON: if (timer == ON_LAST) begin
          state <= OFF;
          timer <= '0;
          led   <= 1'b0;
        end else begin
          timer <= timer + 1'b1;
        end
        OFF: if (timer == OFF_LAST) begin
          timer <= '0;
          // A fresh event in the final dark cycle wins over the queue, leaving pending intact.
          if (ev || pend_nz) begin
            state <= ON;
            led   <= 1'b1;
`ifdef LED_STRETCH_QUEUE_EN
            if (!ev) pend <= pend - 1'b1;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          timer <= timer + 1'b1;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      if (ev_extra) begin
`ifdef LED_STRETCH_QUEUE_EN
        if (pend == PEND_MAX) ovf  <= 1'b1;
        else                  pend <= pend + 1'b1;
`else
        ovf <= 1'b1;
`endif
      end
    end
  end

  assign bus.o_LED_1    = led;
  assign bus.o_Busy     = busy;
  assign bus.o_Overflow = ovf;
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher (ON=4, OFF=3, PEND_W=2); expectations follow the
// build mode selected by LED_STRETCH_QUEUE_EN.
module tb_led_pulse_stretcher;
  localparam int W = 48;
`ifdef LED_STRETCH_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W:0] led_log, busy_log, ovf_log;
  logic [W:0] e_led, e_busy, e_ovf, zero;

  led_pulse_stretcher_if bus();

  led_pulse_stretcher #(.ON_CYCLES(4), .OFF_CYCLES(3), .PEND_W(2)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] rng(input int a, input int b);
    logic [W:0] r;
    r = '0;
    for (int i = a; i <= b; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic do_reset;
    bus.i_Event = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle k is the period ending at edge k; ev[k] is sampled at edge k.
  task automatic run(input logic [W:0] ev, input int n);
    led_log = '0; busy_log = '0; ovf_log = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      led_log[k]  = bus.o_LED_1;
      busy_log[k] = bus.o_Busy;
      ovf_log[k]  = bus.o_Overflow;
      bus.i_Event = ev[k];
    end
    @(negedge clk);
    bus.i_Event = 1'b0;
  endtask

  task automatic test_reset;
    bus.i_Event = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_LED_1 !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", bus.o_LED_1); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_Busy); end
    checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.o_Overflow); end
    bus.i_Event = 1'b0;
    rst_n = 1'b1;
    run(rng(5, 5), 16);
    checks++; if (led_log !== rng(6, 9)) begin errors++; $display("FAIL reset_first_led got %h want %h", led_log, rng(6, 9)); end
    checks++; if (busy_log !== rng(6, 12)) begin errors++; $display("FAIL reset_first_busy got %h want %h", busy_log, rng(6, 12)); end
    checks++; if (ovf_log !== zero) begin errors++; $display("FAIL reset_first_ovf got %h want %h", ovf_log, zero); end
  endtask

  task automatic test_single;
    do_reset();
    run(rng(10, 10), 24);
    checks++; if (led_log !== rng(11, 14)) begin errors++; $display("FAIL single_led got %h want %h", led_log, rng(11, 14)); end
    checks++; if (busy_log !== rng(11, 17)) begin errors++; $display("FAIL single_busy got %h want %h", busy_log, rng(11, 17)); end
    checks++; if (ovf_log !== zero) begin errors++; $display("FAIL single_ovf got %h want %h", ovf_log, zero); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    run(rng(10, 10) | rng(12, 13), 36);
    if (QUEUE) begin
      e_led = rng(11, 14) | rng(18, 21) | rng(25, 28); e_busy = rng(11, 31); e_ovf = '0;
    end else begin
      e_led = rng(11, 14); e_busy = rng(11, 17); e_ovf = rng(13, 14);
    end
    checks++; if (led_log !== e_led) begin errors++; $display("FAIL b2b_led got %h want %h", led_log, e_led); end
    checks++; if (busy_log !== e_busy) begin errors++; $display("FAIL b2b_busy got %h want %h", busy_log, e_busy); end
    checks++; if (ovf_log !== e_ovf) begin errors++; $display("FAIL b2b_ovf got %h want %h", ovf_log, e_ovf); end
  endtask

  task automatic test_overflow;
    do_reset();
    run(rng(10, 15), 45);
    if (QUEUE) begin
      e_led = rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35); e_busy = rng(11, 38); e_ovf = rng(15, 16);
    end else begin
      e_led = rng(11, 14); e_busy = rng(11, 17); e_ovf = rng(12, 16);
    end
    checks++; if (led_log !== e_led) begin errors++; $display("FAIL ovf_led got %h want %h", led_log, e_led); end
    checks++; if (busy_log !== e_busy) begin errors++; $display("FAIL ovf_busy got %h want %h", busy_log, e_busy); end
    checks++; if (ovf_log !== e_ovf) begin errors++; $display("FAIL ovf_pulse got %h want %h", ovf_log, e_ovf); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    run(rng(9, 11), 11);
    checks++; if (bus.o_LED_1 !== 1'b1) begin errors++; $display("FAIL mid_led_before got %b want 1", bus.o_LED_1); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_LED_1 !== 1'b0) begin errors++; $display("FAIL mid_led_async got %b want 0", bus.o_LED_1); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b want 0", bus.o_Busy); end
    checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_async got %b want 0", bus.o_Overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    run(zero, 30);
    checks++; if (led_log !== zero) begin errors++; $display("FAIL mid_replay_led got %h want %h", led_log, zero); end
    checks++; if (busy_log !== zero) begin errors++; $display("FAIL mid_replay_busy got %h want %h", busy_log, zero); end
  endtask

  task automatic test_final_off;
    do_reset();
    run(rng(10, 10) | rng(12, 12) | rng(17, 17), 36);
    if (QUEUE) begin
      e_led = rng(11, 14) | rng(18, 21) | rng(25, 28); e_busy = rng(11, 31); e_ovf = '0;
    end else begin
      e_led = rng(11, 14) | rng(18, 21); e_busy = rng(11, 24); e_ovf = rng(13, 13);
    end
    checks++; if (led_log !== e_led) begin errors++; $display("FAIL final_off_led got %h want %h", led_log, e_led); end
    checks++; if (busy_log !== e_busy) begin errors++; $display("FAIL final_off_busy got %h want %h", busy_log, e_busy); end
    checks++; if (ovf_log !== e_ovf) begin errors++; $display("FAIL final_off_ovf got %h want %h", ovf_log, e_ovf); end
  endtask

  initial begin
    zero = '0;
    bus.i_Event = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_final_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Converts single-cycle event strobes into human-visible LED flashes with a guaranteed minimum on-time and a guaranteed minimum dark gap between consecutive flashes. Events that arrive while a flash is in progress are queued in a saturating pending counter and replayed back-to-back, so none are silently lost. It is the output-side companion to the switch debouncer: the debouncer turns slow, noisy physical input into clean single-cycle pulses, and this block turns fast internal pulses into slow physical output on an LED pin.

## Interface
- ON_CYCLES, 250000: LED high duration in clocks (10 ms at 25 MHz); must be ≥1.
- OFF_CYCLES, 250000: minimum LED dark gap after each flash, in clocks; must be ≥1.
- PEND_W, 4: pending-counter width; maximum queued events is 2^PEND_W−1.

Ports:
- i_Clk, input, 1: single system clock; all logic on rising edge.
- i_Rst_L, input, 1: asynchronous, active-low reset.
- i_Event, input, 1: event strobe, sampled every rising edge; each high cycle counts as one event.
- o_LED_1, output, 1: LED drive, registered.
- o_Busy, output, 1: high whenever the state is not IDLE.
- o_Overflow, output, 1: one-cycle pulse for each event that is dropped.

## Operation
- State machine: IDLE, ON, OFF.
- Timer width is the bit width of max(ON_CYCLES, OFF_CYCLES). It resets to 0 on every state entry.
- Transitions out of IDLE:
  - With i_Event=1, go to ON. Pending is unchanged.
- Transitions out of ON:
  - The timer counts up.
  - When timer reaches ON_CYCLES−1, go to OFF.
- Transitions out of OFF:
  - The timer counts up.
  - When timer reaches OFF_CYCLES−1, apply these rules:
    - i_Event=1: go to ON; pending is unchanged.
    - Otherwise, pending>0: go to ON; pending decrements by 1.
    - Otherwise: go to IDLE.
- Event in any other ON or OFF cycle: pending increments by 1.
  - If pending is already 2^PEND_W−1, pending holds and o_Overflow pulses high in the next cycle.
- Outputs:
  - o_LED_1 is high exactly while the state is ON.
  - o_Busy is high while the state is ON or OFF.
- Reset (asynchronous assert, at any time including mid-flash):
  - State goes to IDLE; timer, pending, o_LED_1, o_Busy and o_Overflow all go to 0 immediately.
  - After deassertion, the first event is accepted on the first rising edge.

## Timing
- Event sampled high at edge n: o_LED_1 is high for cycles n+1 … n+ON_CYCLES, then low for at least OFF_CYCLES cycles.
- The next queued flash starts at cycle n+ON_CYCLES+OFF_CYCLES+1. There are no idle bubbles between queued flashes.
- o_Busy rises in the same cycle as o_LED_1. It falls OFF_CYCLES cycles after o_LED_1 falls when nothing is pending.
- o_Overflow is asserted for one cycle, in the cycle after the dropped event.
- A continuous i_Event level is treated as one event per cycle. Upstream must supply edge-detected strobes.

## Configuration
- LED_STRETCH_QUEUE_EN defined:
  - The pending counter is instantiated.
  - Queuing and saturation behave as described in Operation.
- LED_STRETCH_QUEUE_EN undefined:
  - No pending counter; the PEND_W parameter is ignored.
  - Every event arriving in ON, or in OFF before the final OFF cycle, is dropped and pulses o_Overflow.
  - An event in the final OFF cycle still starts a new ON directly.
  - IDLE behaviour is unchanged.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2, with LED_STRETCH_QUEUE_EN defined unless noted.
- Reset: hold i_Rst_L low, then release → o_LED_1, o_Busy and o_Overflow read 0; an event at edge 5 gives LED high in cycles 6–9.
- Single event at edge 10 → LED high in cycles 11–14 and low from cycle 15; o_Busy high in cycles 11–17 and low in cycle 18.
- Events at edges 10, 12 and 13 → three flashes, with LED high in cycles 11–14, 18–21 and 25–28; o_Busy falls in cycle 32; no overflow.
- Events at edges 10 and 11–15 (six events) → 3 queued, 2 overflow pulses in cycles 15 and 16, and 4 flashes in total.
- Reset asserted in cycle 12 mid-ON with 2 events pending → LED 0 immediately; after release, no replayed flashes.
- LED_STRETCH_QUEUE_EN undefined: events at edges 10, 12 and 17 → the event at 12 is dropped with an overflow pulse in cycle 13; the event at 17 (final OFF cycle) starts a flash in cycles 18–21.
